// File: rtl/gate_controller.sv
// Parking-gate sequencer: synchronises/debounces the entry and exit sensors, tracks
// occupancy against CAPACITY and drives a registered open/close command to the servo.
module gate_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic rise_o,
  output logic fall_o
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1_q, s2_q, lvl_q, lvl_prev_q;
  logic [DW-1:0] cnt_q;

  // cnt_q counts consecutive cycles the synchronised value has disagreed with lvl_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= raw_i;
      s2_q       <= s1_q;
      lvl_prev_q <= lvl_q;
      if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_q <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rise_o = lvl_q & ~lvl_prev_q;
  assign fall_o = ~lvl_q & lvl_prev_q;
endmodule

module gate_controller #(
  parameter int CAPACITY        = 8,
  parameter int CNT_W           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  output logic             gate_open,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             entry_denied
);
  localparam int TW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ENTRY_OPEN, EXIT_OPEN, HOLD} state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [1:0]    raw, rise, fall;  // lane 0 = entry, lane 1 = exit
  logic          exit_ok, entry_ok;

  assign raw = {exit_sensor, entry_sensor};

  gate_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [1:0] (
    .clk   (clk),
    .rst_n (reset),
    .raw_i (raw),
    .rise_o(rise),
    .fall_o(fall)
  );

  assign exit_ok  = rise[1] && (occupancy != '0);
  assign entry_ok = rise[0] && !full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      gate_open    <= 1'b0;
      occupancy    <= '0;
      full         <= 1'b0;
      entry_denied <= 1'b0;
    end else begin
      entry_denied <= 1'b0;
      case (state_q)
        IDLE, HOLD: begin
          if (exit_ok) begin
            state_q   <= EXIT_OPEN;
            gate_open <= 1'b1;
          end else if (entry_ok) begin
            state_q   <= ENTRY_OPEN;
            gate_open <= 1'b1;
          end else begin
            // an entry rise that was not accepted here can only mean the lot is full
            entry_denied <= rise[0];
            if (state_q == HOLD) begin
              if (timer_q == TW'(1)) begin
                state_q   <= IDLE;
                gate_open <= 1'b0;
              end else begin
                timer_q <= timer_q - 1'b1;
              end
            end
          end
        end
        ENTRY_OPEN: begin
          if (fall[0]) begin
            if (occupancy != CNT_W'(CAPACITY)) occupancy <= occupancy + 1'b1;
            full    <= (occupancy >= CNT_W'(CAPACITY - 1));
            state_q <= HOLD;
            timer_q <= TW'(HOLD_CYCLES);
          end
        end
        EXIT_OPEN: begin
          if (fall[1]) begin
            if (occupancy != '0) occupancy <= occupancy - 1'b1;
            full    <= 1'b0;
            state_q <= HOLD;
            timer_q <= TW'(HOLD_CYCLES);
          end
        end
        default: begin
          state_q   <= IDLE;
          gate_open <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gate_controller.sv
// Self-checking bench for gate_controller: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural lot/gate model.
module tb_gate_controller;
  localparam int CAP = 8, CW = 4, DEB = 4, HOLD = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          entry_sensor = 1'b0;
  logic          exit_sensor = 1'b0;
  logic          gate_open, full, entry_denied;
  logic [CW-1:0] occupancy;

  int errors = 0;
  int checks = 0;

  gate_controller #(.CAPACITY(CAP), .CNT_W(CW), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .reset       (reset),
    .entry_sensor(entry_sensor),
    .exit_sensor (exit_sensor),
    .gate_open   (gate_open),
    .occupancy   (occupancy),
    .full        (full),
    .entry_denied(entry_denied)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw samples reach the debouncer two edges late; a lane's level
  // flips after DEB consecutive disagreeing samples; the lot reacts one edge later.
  int m_occ = 0, m_mode = 0, m_left = 0;  // mode: 0 closed, 1 entering, 2 leaving, 3 holding
  bit m_gate = 0, m_full = 0, m_denied = 0;
  bit m_d1[2], m_d2[2], m_lvl[2], m_rise[2], m_fall[2];
  int m_run[2];

  initial begin
    for (int l = 0; l < 2; l++) begin
      m_d1[l] = 0; m_d2[l] = 0; m_lvl[l] = 0; m_rise[l] = 0; m_fall[l] = 0; m_run[l] = 0;
    end
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_occ = 0; m_mode = 0; m_left = 0; m_gate = 0; m_full = 0; m_denied = 0;
        for (int l = 0; l < 2; l++) begin
          m_d1[l] = 0; m_d2[l] = 0; m_lvl[l] = 0; m_rise[l] = 0; m_fall[l] = 0; m_run[l] = 0;
        end
      end else begin
        m_denied = 0;
        if (m_mode == 0 || m_mode == 3) begin
          if (m_rise[1] && m_occ > 0) m_mode = 2;
          else if (m_rise[0] && m_occ < CAP) m_mode = 1;
          else begin
            m_denied = m_rise[0];
            if (m_mode == 3) begin
              m_left--;
              if (m_left == 0) m_mode = 0;
            end
          end
        end else if (m_mode == 1 && m_fall[0]) begin
          if (m_occ < CAP) m_occ++;
          m_mode = 3; m_left = HOLD;
        end else if (m_mode == 2 && m_fall[1]) begin
          if (m_occ > 0) m_occ--;
          m_mode = 3; m_left = HOLD;
        end
        m_gate = (m_mode != 0);
        m_full = (m_occ == CAP);
        for (int l = 0; l < 2; l++) begin
          bit use_v;
          use_v = m_d2[l];
          m_d2[l] = m_d1[l];
          m_d1[l] = (l == 1) ? exit_sensor : entry_sensor;
          m_rise[l] = 0; m_fall[l] = 0;
          if (use_v != m_lvl[l]) begin
            m_run[l]++;
            if (m_run[l] == DEB) begin
              m_lvl[l] = use_v; m_run[l] = 0; m_rise[l] = use_v; m_fall[l] = !use_v;
            end
          end else m_run[l] = 0;
        end
      end
    end
  end

  task automatic do_entry();
    entry_sensor = 1'b1;
    repeat (8) @(negedge clk);
    entry_sensor = 1'b0;
    repeat (HOLD + 12) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; entry_sensor = 1'b0; exit_sensor = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (gate_open !== 1'b0) begin errors++; $display("FAIL reset_gate: got %b expected 0", gate_open); end
    if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    if (entry_denied !== 1'b0) begin errors++; $display("FAIL reset_denied: got %b expected 0", entry_denied); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_entry_latency();
    int k = -1, n = 0;
    bit seen = 0;
    entry_sensor = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      if (gate_open && k < 0) k = e;
    end
    entry_sensor = 1'b0;
    checks++;
    if (k != DEB + 2) begin errors++; $display("FAIL open_latency: got %0d expected %0d", k, DEB + 2); end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (occupancy == 4'd1) seen = 1;
    end
    checks += 2;
    if (!seen) begin errors++; $display("FAIL entry_occ: got %0d expected 1", occupancy); end
    if (gate_open !== 1'b1) begin errors++; $display("FAIL gate_at_clear: got %b expected 1", gate_open); end
    for (n = 1; n < 40; n++) begin
      @(negedge clk);
      if (!gate_open) break;
    end
    checks += 2;
    if (n != HOLD) begin errors++; $display("FAIL hold_len: got %0d expected %0d", n, HOLD); end
    if (full !== 1'b0) begin errors++; $display("FAIL full_after_one: got %b expected 0", full); end
  endtask

  task automatic test_glitch();
    int start_occ = int'(occupancy);
    bit opened = 0;
    entry_sensor = 1'b1;
    repeat (3) @(negedge clk);
    entry_sensor = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (gate_open) opened = 1;
    end
    checks += 2;
    if (opened) begin errors++; $display("FAIL glitch_gate: got 1 expected 0"); end
    if (int'(occupancy) != start_occ) begin
      errors++; $display("FAIL glitch_occ: got %0d expected %0d", occupancy, start_occ);
    end
  endtask

  task automatic test_fill();
    int den = 0;
    bit opened = 0;
    while (occupancy < 4'd7) do_entry();
    checks += 2;
    if (occupancy !== 4'd7) begin errors++; $display("FAIL occ_seven: got %0d expected 7", occupancy); end
    if (full !== 1'b0) begin errors++; $display("FAIL full_at_seven: got %b expected 0", full); end
    do_entry();
    checks += 2;
    if (occupancy !== 4'd8) begin errors++; $display("FAIL occ_eight: got %0d expected 8", occupancy); end
    if (full !== 1'b1) begin errors++; $display("FAIL full_at_eight: got %b expected 1", full); end
    entry_sensor = 1'b1;
    repeat (12) begin
      @(negedge clk);
      den += int'(entry_denied);
      if (gate_open) opened = 1;
    end
    entry_sensor = 1'b0;
    repeat (20) begin
      @(negedge clk);
      den += int'(entry_denied);
      if (gate_open) opened = 1;
    end
    checks += 3;
    if (den != 1) begin errors++; $display("FAIL denied_pulses: got %0d expected 1", den); end
    if (opened) begin errors++; $display("FAIL denied_gate: got 1 expected 0"); end
    if (occupancy !== 4'd8) begin errors++; $display("FAIL denied_occ: got %0d expected 8", occupancy); end
  endtask

  task automatic test_simultaneous();
    int den = 0;
    bit opened = 0;
    entry_sensor = 1'b1; exit_sensor = 1'b1;
    repeat (8) begin
      @(negedge clk);
      den += int'(entry_denied);
      if (gate_open) opened = 1;
    end
    entry_sensor = 1'b0; exit_sensor = 1'b0;
    repeat (HOLD + 14) begin
      @(negedge clk);
      den += int'(entry_denied);
    end
    checks += 4;
    if (!opened) begin errors++; $display("FAIL simul_open: got 0 expected 1"); end
    if (den != 0) begin errors++; $display("FAIL simul_denied: got %0d expected 0", den); end
    if (occupancy !== 4'd7) begin errors++; $display("FAIL simul_occ: got %0d expected 7", occupancy); end
    if (full !== 1'b0) begin errors++; $display("FAIL simul_full: got %b expected 0", full); end
  endtask

  task automatic test_exit_in_hold();
    bit seen = 0, dropped = 0;
    int n;
    entry_sensor = 1'b1;
    repeat (8) @(negedge clk);
    entry_sensor = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (occupancy == 4'd8) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL hold_entry_occ: got %0d expected 8", occupancy); end
    seen = 0;
    exit_sensor = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!gate_open) dropped = 1;
    end
    exit_sensor = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!gate_open) dropped = 1;
      if (occupancy == 4'd7) seen = 1;
    end
    checks += 2;
    if (!seen) begin errors++; $display("FAIL hold_exit_occ: got %0d expected 7", occupancy); end
    if (dropped) begin errors++; $display("FAIL hold_gate_drop: got 0 expected 1"); end
    for (n = 1; n < 40; n++) begin
      @(negedge clk);
      if (!gate_open) break;
    end
    checks++;
    if (n != HOLD) begin errors++; $display("FAIL hold_restart: got %0d expected %0d", n, HOLD); end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    entry_sensor = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (gate_open) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_open: got 0 expected 1"); end
    #2 reset = 1'b0;
    #1;
    checks += 3;
    if (gate_open !== 1'b0) begin errors++; $display("FAIL mid_reset_gate: got %b expected 0", gate_open); end
    if (occupancy !== 4'd0) begin errors++; $display("FAIL mid_reset_occ: got %0d expected 0", occupancy); end
    if (full !== 1'b0) begin errors++; $display("FAIL mid_reset_full: got %b expected 0", full); end
    @(negedge clk);
    entry_sensor = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    do_entry();
    checks += 2;
    if (occupancy !== 4'd1) begin errors++; $display("FAIL post_reset_occ: got %0d expected 1", occupancy); end
    if (gate_open !== 1'b0) begin errors++; $display("FAIL post_reset_gate: got %b expected 0", gate_open); end
  endtask

  task automatic test_random();
    int left_en = 0, left_ex = 0;
    @(negedge clk);
    reset = 1'b0; entry_sensor = 1'b0; exit_sensor = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      if (left_en == 0) begin
        entry_sensor = 1'($urandom_range(0, 1));
        left_en = int'($urandom_range(1, 14));
      end
      if (left_ex == 0) begin
        exit_sensor = ($urandom_range(0, 2) == 0);
        left_ex = int'($urandom_range(1, 14));
      end
      left_en--; left_ex--;
      @(negedge clk);
      checks += 4;
      if (gate_open !== m_gate) begin
        errors++; $display("FAIL rand_gate c=%0d: got %b expected %b", c, gate_open, m_gate);
      end
      if (occupancy !== 4'(m_occ)) begin
        errors++; $display("FAIL rand_occ c=%0d: got %0d expected %0d", c, occupancy, m_occ);
      end
      if (full !== m_full) begin
        errors++; $display("FAIL rand_full c=%0d: got %b expected %b", c, full, m_full);
      end
      if (entry_denied !== m_denied) begin
        errors++; $display("FAIL rand_denied c=%0d: got %b expected %b", c, entry_denied, m_denied);
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry_latency();
    test_glitch();
    test_fill();
    test_simultaneous();
    test_exit_in_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
